// File: rtl/fifo_sync_param.sv
// Single-clock FIFO on an inferred simple-dual-port RAM with threshold flags, fill count and optional FWFT output stage.
// Optional sticky overflow/underflow flags are built when FIFO_SYNC_PARAM_ERR_EN is defined.
//   state   | meaning (FWFT output stage)
//   S_EMPTY | output register empty, prefetch issued as soon as RAM holds a word
//   S_HOLD  | output register holds the head word, rd_valid=1
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_THRESH  = 460,
  parameter int AE_THRESH  = 51,
  parameter int FWFT_MODE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_dv,
  input  logic [DATA_WIDTH-1:0] wr_DATA,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_DATA,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  input  logic                  err_clr,
  output logic                  wr_overflow,
  output logic                  rd_underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_T    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_T    = AE_THRESH[ADDR_WIDTH:0];

  generate
    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_dw
      $error("fifo_sync_param: DATA_WIDTH out of range 1..32");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_param: AE_THRESH out of range 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_full         = (fill_count == DEPTH_C);
  assign wr_almost_full  = (fill_count >= AF_T);
  assign rd_almost_empty = (fill_count <= AE_T);
  assign wr_acc          = wr_dv && !wr_full;
  assign rd_acc          = rd_en && !rd_empty;

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wr_DATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      fill_count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   fill_count <= fill_count + 1'b1;
        2'b01:   fill_count <= fill_count - 1'b1;
        default: ;
      endcase
    end
  end

  generate
    if (FWFT_MODE == 0) begin : g_std
      assign rd_empty = (fill_count == '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rptr     <= '0;
          rd_DATA  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_DATA <= mem[rptr];
            rptr    <= rptr + 1'b1;
          end
        end
      end
    end else begin : g_fwft
      typedef enum logic {S_EMPTY, S_HOLD} state_t;
      state_t state;
      logic   ram_has;

      // fill_count counts the output register, so RAM occupancy is fill_count minus rd_valid.
      assign ram_has  = (fill_count != {{ADDR_WIDTH{1'b0}}, rd_valid});
      assign rd_valid = (state == S_HOLD);
      assign rd_empty = (state != S_HOLD);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state   <= S_EMPTY;
          rptr    <= '0;
          rd_DATA <= '0;
        end else begin
          case (state)
            S_EMPTY: begin
              if (ram_has) begin
                rd_DATA <= mem[rptr];
                rptr    <= rptr + 1'b1;
                state   <= S_HOLD;
              end
            end
            S_HOLD: begin
              if (rd_acc) begin
                if (ram_has) begin
                  rd_DATA <= mem[rptr];
                  rptr    <= rptr + 1'b1;
                end else begin
                  state <= S_EMPTY;
                end
              end
            end
            default: state <= S_EMPTY;
          endcase
        end
      end
    end
  endgenerate

`ifdef FIFO_SYNC_PARAM_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else if (err_clr) begin
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (wr_dv && wr_full)  wr_overflow  <= 1'b1;
      if (rd_en && rd_empty) rd_underflow <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign wr_overflow    = 1'b0;
  assign rd_underflow   = 1'b0;
`endif

endmodule
